// File: rtl/mult_matrix_collect.sv
// mult_matrix_collect: result collector that sits behind mult_matrix_revert.
// After a start pulse it waits a fixed pipeline latency, captures size rows
// into a size x size buffer, then drains one row per valid/ready handshake.
// Optional build macro MULT_MATRIX_COLLECT_TRANSPOSE_EN: when defined, the
// drain emits buffer columns instead of rows (transposed result).
module mult_matrix_collect #(
   parameter  int data_size = 4,
   parameter  int size      = 3,
   parameter  int latency   = 5,
   localparam int IW        = (size > 1) ? $clog2(size) : 1,
   localparam int W         = data_size * size
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [W-1:0]  input_stream,
   output logic [W-1:0]  row_out,
   output logic [IW-1:0] row_index,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          busy,
   output logic          done
);

   // Wait counter must hold latency itself without wrapping.
   localparam int WCW = (latency > 0) ? $clog2(latency + 1) : 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_CAPTURE = 2'd2,
      S_OUTPUT  = 2'd3
   } state_t;

   state_t         state_q, state_d;
   logic [WCW-1:0] waitCnt_q, waitCnt_d;
   logic [IW-1:0]  capCnt_q, capCnt_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic           done_q, done_d;
   logic           bufWe;
   logic [W-1:0]   rowBuf_q [size];

   // State, counters and the done flag; everything clears on reset so no
   // partial result can leak out after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         waitCnt_q <= '0;
         capCnt_q  <= '0;
         idx_q     <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         waitCnt_q <= waitCnt_d;
         capCnt_q  <= capCnt_d;
         idx_q     <= idx_d;
         done_q    <= done_d;
      end
   end

   // Result buffer: the capture counter selects which row takes input_stream.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < size; r++) begin
            rowBuf_q[r] <= '0;
         end
      end else if (bufWe) begin
         for (int r = 0; r < size; r++) begin
            if (capCnt_q == IW'(r)) begin
               rowBuf_q[r] <= input_stream;
            end
         end
      end
   end

   // Next-state logic; start is only looked at in IDLE, out_ready only in OUTPUT.
   always_comb begin
      state_d   = state_q;
      waitCnt_d = waitCnt_q;
      capCnt_d  = capCnt_q;
      idx_d     = idx_q;
      done_d    = 1'b0;
      bufWe     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               waitCnt_d = WCW'(latency);
               capCnt_d  = '0;
               state_d   = (latency == 0) ? S_CAPTURE : S_WAIT;
            end
         end
         S_WAIT: begin
            if (waitCnt_q <= WCW'(1)) begin
               waitCnt_d = '0;
               state_d   = S_CAPTURE;
            end else begin
               waitCnt_d = waitCnt_q - WCW'(1);
            end
         end
         S_CAPTURE: begin
            bufWe = 1'b1;
            if (capCnt_q == IW'(size - 1)) begin
               capCnt_d = '0;
               idx_d    = '0;
               state_d  = S_OUTPUT;
            end else begin
               capCnt_d = capCnt_q + IW'(1);
            end
         end
         S_OUTPUT: begin
            if (out_ready) begin
               if (idx_q == IW'(size - 1)) begin
                  idx_d   = '0;
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output mux: row (or column) idx while draining, zeros otherwise.
   always_comb begin
      out_valid = (state_q == S_OUTPUT);
      busy      = (state_q != S_IDLE);
      done      = done_q;
      row_out   = '0;
      row_index = '0;
      if (out_valid) begin
         row_index = idx_q;
         for (int k = 0; k < size; k++) begin
            if (idx_q == IW'(k)) begin
`ifdef MULT_MATRIX_COLLECT_TRANSPOSE_EN
               for (int j = 0; j < size; j++) begin
                  row_out[(size-j)*data_size-1 -: data_size] =
                     rowBuf_q[j][(size-k)*data_size-1 -: data_size];
               end
`else
               row_out = rowBuf_q[k];
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_mult_matrix_collect.sv
// Directed self-checking bench for mult_matrix_collect (data_size=4, size=3).
// dut uses latency=5; dut0 uses latency=0 for the back-to-back scenario.
module tb_mult_matrix_collect;

   logic        clk;
   logic        rst_n;
   logic        start, start0;
   logic [11:0] inStream, in0;
   logic [11:0] rowOut, rowOut0;
   logic [1:0]  rowIndex, rowIndex0;
   logic        outValid, outValid0;
   logic        outReady, outReady0;
   logic        busy, busy0;
   logic        done, done0;

   int checks;
   int failures;

   logic [11:0] expA [3];
   logic [11:0] expB [3];
   logic [11:0] expC [3];

   mult_matrix_collect #(.data_size(4), .size(3), .latency(5)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .input_stream(inStream),
      .row_out(rowOut), .row_index(rowIndex), .out_valid(outValid),
      .out_ready(outReady), .busy(busy), .done(done)
   );

   mult_matrix_collect #(.data_size(4), .size(3), .latency(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .input_stream(in0),
      .row_out(rowOut0), .row_index(rowIndex0), .out_valid(outValid0),
      .out_ready(outReady0), .busy(busy0), .done(done0)
   );

   // Free-running clock, 10 time-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance past the next rising edge; outputs are sampled 1 unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse start and present three rows on edges 6, 7 and 8 after the start edge.
   task automatic applyStimulus(input logic [11:0] r0, input logic [11:0] r1,
                                input logic [11:0] r2);
      start = 1'b1;
      inStream = 12'hFFF;
      tick();
      start = 1'b0;
      repeat (5) tick();
      inStream = r0;
      tick();
      inStream = r1;
      tick();
      inStream = r2;
      tick();
      inStream = 12'hABC;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      #2;
      checks++; if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", outValid); end
      checks++; if (rowOut !== 12'h000) begin failures++; $display("[TB] FAIL reset_row got=%h exp=000", rowOut); end
      checks++; if (rowIndex !== 2'd0) begin failures++; $display("[TB] FAIL reset_index got=%0d exp=0", rowIndex); end
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
      rst_n = 1'b1;
      tick();
      checks++; if (busy0 !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy0 got=%b exp=0", busy0); end
   endtask

   task automatic test_basic();
      outReady = 1'b1;
      start = 1'b1;
      inStream = 12'hFFF;
      tick();
      start = 1'b0;
      checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL basic_busy_rise got=%b exp=1", busy); end
      repeat (5) tick();
      inStream = 12'h123;
      tick();
      inStream = 12'h456;
      tick();
      checks++; if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL basic_early_valid got=%b exp=0", outValid); end
      inStream = 12'h789;
      tick();
      inStream = 12'hABC;
      for (int i = 0; i < 3; i++) begin
         checks++; if (outValid !== 1'b1) begin failures++; $display("[TB] FAIL basic_valid%0d got=%b exp=1", i, outValid); end
         checks++; if (rowOut !== expA[i]) begin failures++; $display("[TB] FAIL basic_row%0d got=%h exp=%h", i, rowOut, expA[i]); end
         checks++; if (rowIndex !== 2'(i)) begin failures++; $display("[TB] FAIL basic_index%0d got=%0d exp=%0d", i, rowIndex, i); end
         checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL basic_early_done%0d got=%b exp=0", i, done); end
         tick();
      end
      checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL basic_done got=%b exp=1", done); end
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL basic_busy_fall got=%b exp=0", busy); end
      checks++; if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL basic_valid_fall got=%b exp=0", outValid); end
      checks++; if (rowOut !== 12'h000) begin failures++; $display("[TB] FAIL basic_row_zero got=%h exp=000", rowOut); end
      tick();
      checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL basic_done_pulse got=%b exp=0", done); end
   endtask

   task automatic test_backpressure();
      outReady = 1'b1;
      applyStimulus(12'h123, 12'h456, 12'h789);
      checks++; if (rowOut !== expA[0]) begin failures++; $display("[TB] FAIL bp_row0 got=%h exp=%h", rowOut, expA[0]); end
      tick();
      outReady = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++; if (outValid !== 1'b1) begin failures++; $display("[TB] FAIL bp_valid_stall%0d got=%b exp=1", i, outValid); end
         checks++; if (rowOut !== expA[1]) begin failures++; $display("[TB] FAIL bp_row_stall%0d got=%h exp=%h", i, rowOut, expA[1]); end
         checks++; if (rowIndex !== 2'd1) begin failures++; $display("[TB] FAIL bp_index_stall%0d got=%0d exp=1", i, rowIndex); end
         if (i < 4) tick();
      end
      outReady = 1'b1;
      tick();
      checks++; if (rowOut !== expA[2]) begin failures++; $display("[TB] FAIL bp_row2 got=%h exp=%h", rowOut, expA[2]); end
      checks++; if (rowIndex !== 2'd2) begin failures++; $display("[TB] FAIL bp_index2 got=%0d exp=2", rowIndex); end
      tick();
      checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL bp_done got=%b exp=1", done); end
      tick();
   endtask

   task automatic test_start_while_busy();
      int nDone;
      int nValid;
      int nBusy;
      nDone = 0;
      nValid = 0;
      nBusy = 0;
      outReady = 1'b1;
      start = 1'b1;
      inStream = 12'hFFF;
      tick();
      start = 1'b0;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      inStream = 12'h123;
      tick();
      inStream = 12'h456;
      tick();
      inStream = 12'h789;
      tick();
      inStream = 12'hABC;
      for (int i = 0; i < 3; i++) begin
         start = 1'b1;
         checks++; if (outValid !== 1'b1) begin failures++; $display("[TB] FAIL swb_valid%0d got=%b exp=1", i, outValid); end
         checks++; if (rowOut !== expA[i]) begin failures++; $display("[TB] FAIL swb_row%0d got=%h exp=%h", i, rowOut, expA[i]); end
         tick();
      end
      start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (done) nDone++;
         if (outValid) nValid++;
         if (busy) nBusy++;
         tick();
      end
      checks++; if (nDone !== 1) begin failures++; $display("[TB] FAIL swb_done_count got=%0d exp=1", nDone); end
      checks++; if (nValid !== 0) begin failures++; $display("[TB] FAIL swb_extra_valid got=%0d exp=0", nValid); end
      checks++; if (nBusy !== 0) begin failures++; $display("[TB] FAIL swb_restarted got=%0d exp=0", nBusy); end
   endtask

   task automatic test_reset_mid_op();
      int nValid;
      nValid = 0;
      outReady = 1'b1;
      start = 1'b1;
      inStream = 12'hFFF;
      tick();
      start = 1'b0;
      repeat (5) tick();
      inStream = 12'h123;
      tick();
      inStream = 12'h456;
      tick();
      checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL rst_pre_busy got=%b exp=1", busy); end
      rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_busy got=%b exp=0", busy); end
      checks++; if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL rst_valid got=%b exp=0", outValid); end
      checks++; if (rowOut !== 12'h000) begin failures++; $display("[TB] FAIL rst_row got=%h exp=000", rowOut); end
      checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL rst_done got=%b exp=0", done); end
      tick();
      rst_n = 1'b1;
      inStream = 12'h789;
      for (int i = 0; i < 10; i++) begin
         if (outValid || busy) nValid++;
         tick();
      end
      checks++; if (nValid !== 0) begin failures++; $display("[TB] FAIL rst_partial_emit got=%0d exp=0", nValid); end
      applyStimulus(12'hA1B, 12'h2C3, 12'hD4E);
      for (int i = 0; i < 3; i++) begin
         checks++; if (rowOut !== expB[i]) begin failures++; $display("[TB] FAIL rst_fresh_row%0d got=%h exp=%h", i, rowOut, expB[i]); end
         checks++; if (rowIndex !== 2'(i)) begin failures++; $display("[TB] FAIL rst_fresh_index%0d got=%0d exp=%0d", i, rowIndex, i); end
         tick();
      end
      checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL rst_fresh_done got=%b exp=1", done); end
      tick();
   endtask

   task automatic test_back_to_back();
      outReady0 = 1'b1;
      start0 = 1'b1;
      in0 = 12'hFFF;
      tick();
      start0 = 1'b0;
      in0 = 12'h123;
      tick();
      in0 = 12'h456;
      tick();
      in0 = 12'h789;
      tick();
      in0 = 12'hABC;
      for (int i = 0; i < 3; i++) begin
         checks++; if (rowOut0 !== expA[i]) begin failures++; $display("[TB] FAIL b2b_first_row%0d got=%h exp=%h", i, rowOut0, expA[i]); end
         tick();
      end
      checks++; if (done0 !== 1'b1) begin failures++; $display("[TB] FAIL b2b_first_done got=%b exp=1", done0); end
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      checks++; if (busy0 !== 1'b1) begin failures++; $display("[TB] FAIL b2b_restart_busy got=%b exp=1", busy0); end
      in0 = 12'h5F0;
      tick();
      in0 = 12'h0E6;
      tick();
      checks++; if (outValid0 !== 1'b0) begin failures++; $display("[TB] FAIL b2b_early_valid got=%b exp=0", outValid0); end
      in0 = 12'h9D7;
      tick();
      in0 = 12'hABC;
      for (int i = 0; i < 3; i++) begin
         checks++; if (outValid0 !== 1'b1) begin failures++; $display("[TB] FAIL b2b_valid%0d got=%b exp=1", i, outValid0); end
         checks++; if (rowOut0 !== expC[i]) begin failures++; $display("[TB] FAIL b2b_row%0d got=%h exp=%h", i, rowOut0, expC[i]); end
         checks++; if (rowIndex0 !== 2'(i)) begin failures++; $display("[TB] FAIL b2b_index%0d got=%0d exp=%0d", i, rowIndex0, i); end
         tick();
      end
      checks++; if (done0 !== 1'b1) begin failures++; $display("[TB] FAIL b2b_second_done got=%b exp=1", done0); end
      tick();
   endtask

   // Test sequence; expected rows depend on whether the transposed build is used.
   initial begin
      checks = 0;
      failures = 0;
`ifdef MULT_MATRIX_COLLECT_TRANSPOSE_EN
      expA[0] = 12'h147; expA[1] = 12'h258; expA[2] = 12'h369;
      expB[0] = 12'hA2D; expB[1] = 12'h1C4; expB[2] = 12'hB3E;
      expC[0] = 12'h509; expC[1] = 12'hFED; expC[2] = 12'h067;
`else
      expA[0] = 12'h123; expA[1] = 12'h456; expA[2] = 12'h789;
      expB[0] = 12'hA1B; expB[1] = 12'h2C3; expB[2] = 12'hD4E;
      expC[0] = 12'h5F0; expC[1] = 12'h0E6; expC[2] = 12'h9D7;
`endif
      rst_n = 1'b0;
      start = 1'b0;
      start0 = 1'b0;
      inStream = 12'h000;
      in0 = 12'h000;
      outReady = 1'b0;
      outReady0 = 1'b0;
      test_reset();
      test_basic();
      test_backpressure();
      test_start_while_busy();
      test_reset_mid_op();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mult_matrix_collect.md
# mult_matrix_collect

Result collector placed directly downstream of `mult_matrix_revert`. It consumes the de-skewed, row-parallel stream leaving the systolic multiplier and counts a fixed pipeline latency after a `start` pulse. It then captures `size` consecutive rows into an internal `size`×`size` result buffer and drains them one row per handshake over a valid/ready interface to the next stage.

## Interface
- `data_size`, 4, width of one matrix element in bits
- `size`, 3, matrix dimension, which is also the lane count
- `latency`, 5, cycles between the `start` edge and the first valid row on `input_stream`; legal range 0..255

- `clk`  in  1  clock; all state changes on the rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `start`  in  1  one-cycle pulse marking operand injection into the array
- `input_stream`  in  `data_size*size`  de-skewed row; lane j occupies bits `[(size-j)*data_size-1 -: data_size]`, so lane 0 is in the MSBs
- `row_out`  out  `data_size*size`  row being offered; same lane packing as `input_stream`
- `row_index`  out  `$clog2(size)` (minimum 1)  index of the offered row
- `out_valid`  out  1  `row_out` and `row_index` are valid
- `out_ready`  in  1  downstream accepts the offered row
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse after the final row is accepted

## Operation
- The state machine has four states: IDLE, WAIT, CAPTURE and OUTPUT.
- IDLE:
  - `start`=1 at edge E0 loads the wait counter with `latency`.
  - It goes to WAIT, or directly to CAPTURE when `latency`=0.
  - `start` is ignored in every other state, with no queuing.
- WAIT: the counter decrements each edge. On the edge where it reaches 0, the block goes to CAPTURE.
- CAPTURE:
  - `input_stream` is sampled into buffer row r at edge E0+`latency`+1+r, for r = 0..`size`-1.
  - The capture counter counts 0..`size`-1.
  - The edge that stores row `size`-1 moves the block to OUTPUT with the output index at 0.
- OUTPUT:
  - `out_valid`=1, `row_out`=buffer[idx], `row_index`=idx.
  - An edge with `out_valid`&&`out_ready` advances idx.
  - The handshake on idx=`size`-1 returns the block to IDLE and sets `done` for the following cycle.
- `row_out` and `row_index` are driven to 0 whenever `out_valid`=0.
- No arithmetic is performed. Elements are stored and forwarded bit-exact.
- Counters are sized to hold their maximum value without wrap-around.

## Timing
- Reset (`rst_n` low, at any time including mid-CAPTURE or mid-OUTPUT):
  - State returns to IDLE.
  - All counters and the buffer clear to 0.
  - `out_valid`=0, `row_out`=0, `row_index`=0, `busy`=0, `done`=0.
  - No partial result is emitted after release.
- Latency from `start` to first `out_valid`: `latency`+`size`+1 cycles. With the defaults this is 9: `out_valid` goes high in the cycle after edge E0+8.
- `out_valid` stays high through all `size` rows and is never deasserted while `out_ready` is low.
- `row_out` is held stable while stalled.
- With `out_ready` tied high, the drain takes exactly `size` cycles.
- `busy` rises the cycle after the `start` edge and falls together with `out_valid` after the last handshake.
- `done` is high for exactly one cycle, the cycle after the last handshake, and coincides with `busy`=0.
- The earliest accepted next `start` is in the same cycle that `done` is high.
- A `start` asserted in the cycle of the final handshake is ignored, because the state is still OUTPUT.
- `out_ready` is ignored outside OUTPUT.

## Configuration
- `MULT_MATRIX_COLLECT_TRANSPOSE_EN`
  - Defined: in OUTPUT, `row_out` carries column idx of the buffer instead of row idx. Lane j holds element [j][idx], so the result is emitted transposed. `row_index` then names the column.
  - Not defined: rows are emitted as captured.
  - State machine, handshake and timing are identical in both builds.

## Test plan
All cases use `data_size`=4, `size`=3, `latency`=5.

- **Basic:** `start` at edge 0; rows 0x123, 0x456, 0x789 presented on edges 6, 7, 8; `out_ready`=1 → `row_out` reads 0x123, 0x456, 0x789 with `row_index` 0, 1, 2 on consecutive cycles; then `done` pulses once.
- **Transpose:** same stimulus with `MULT_MATRIX_COLLECT_TRANSPOSE_EN` defined → `row_out` reads 0x147, 0x258, 0x369.
- **Backpressure:** `out_ready` low for 4 cycles while row 1 is offered → `row_out`=0x456 and `row_index`=1 are held stable; `out_valid` stays 1; no row is skipped.
- **Start while busy:** `start` pulses during WAIT and during OUTPUT → ignored; exactly 3 rows are emitted and `done` pulses once.
- **Reset mid-op:** `rst_n` low for 1 cycle while the block is in CAPTURE after row 1 → all outputs go to 0 immediately; after release the block is in IDLE; a new `start` produces fresh data only.
- **Back-to-back:** a new `start` in the `done` cycle, with `latency`=0 build → second capture begins on the next edge; first `out_valid` appears 4 cycles after that `start` edge.
